spi_master_regs: RTL and testbench
==================================

# spi_master_regs

Byte-wide control/status register file for the SPI master peripheral. It sits between the Wishbone slave logic (wb_clk domain) and the serializer/deserializer engine. It holds the clock divisor, mode bits, chip-select, bit-count and transmit data. It issues transfer commands, tracks transfer-in-progress and raises the fabric interrupt.

## Interface
- No parameters.
- Reset is `rst`: asynchronous, active-high. Clock is `wb_clk`.
- wb_clk  in  1  bus clock; all state is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rst_sync_i  in  1  synchronous reset. Same effect as rst, applied at the clock edge.
- ad_i  in  3  register address (byte-address bits [4:2]).
- wr_i  in  1  write strobe, one cycle per access.
- data_i  in  8  write data.
- data_o  out  8  read data, combinational from ad_i.
- divisor_o  out  16  SCK divisor.
- spe_o, bidiroen_o, spc0_o, cpol_o, cpha_o, lsbfe_o  out  1 each  mode bits.
- ext_spi_clk_en_o  out  1  extra-clock enable.
- ext_spi_clk_cnt_o  out  3  extra-clock count.
- spi_bit_ctrl_o  out  3  bits-per-transfer code.
- start_o, stop_o, read_o, write_o  out  1 each  pending command bits.
- trnfer_cmplte_i  in  1  one-cycle pulse from the engine when a command finishes.
- spi_write_data_o  out  8  TX byte.
- spi_read_data_i  in  8  RX byte from the engine.
- spi_cs_reg_o  out  8  chip-select register, active-low per bit.
- irq_read_i, irq_write_i  in  1 each  engine event pulses.
- intr_o  out  1  interrupt request.
- tip_o  out  1  transfer in progress.

## Operation
Register map (address: write / read):
- 0: DIV_LO. Sets divisor[7:0]. Reads back.
- 1: DIV_HI. Sets divisor[15:8]. Reads back.
- 2: CTRL. Bit 7 SPE, 6 IEN, 5 BIDIROEn, 4 SPC0, 3 CPOL, 2 CPHA, 1 LSBFE, 0 Ext_SPI_Clk_En. Reads back.
- 3 write: CMD. Bit 7 START, 6 STOP, 5 READ, 4 WRITE, 0 IACK. Other bits ignored.
- 3 read: STATUS. {TIP, 4'b0, irq_write_i, irq_read_i, IF}.
- 4: TX data (write); reads return the RX value.
- 5: CS. Reads back.
- 6: BITCTRL. Bits [2:0] bit_ctrl, [6:4] ext_clk_cnt. Reads back, bit 7 and bit 3 as 0.
- 7: Writes ignored. Reads return 0x00.

Command bits:
- A CMD write with SPE=1 loads bits 7:4 into start/stop/read/write.
- A CMD write with SPE=0 leaves the command bits unchanged; IACK is still honoured.
- Command bits hold until trnfer_cmplte_i, which clears all four.
- If a CMD write (SPE=1) and trnfer_cmplte_i occur in the same cycle, the write wins.
- tip_o is the OR of the four command bits.

Interrupt:
- IF sets on trnfer_cmplte_i, irq_read_i or irq_write_i.
- IF clears on a CMD write with IACK=1.
- If set and clear occur in the same cycle, set wins.
- intr_o = IF & IEN, registered.

Reset (rst or rst_sync_i):
- All registers are 0. divisor = 0x0000, cs = 0xFF.
- All outputs low except spi_cs_reg_o = 0xFF.

## Timing
- Writes take effect on the wb_clk edge where wr_i=1. Outputs update the same edge.
- Reads are combinational, zero latency.
- intr_o lags IF/IEN by one cycle.
- trnfer_cmplte_i clears the command bits at the next edge; tip_o falls then.
- Asynchronous reset mid-transfer clears everything immediately. The engine sees tip_o=0.

## Configuration
- Macro `SPIREGS_RX_CAPTURE_EN`.
- Defined: an 8-bit RX register captures spi_read_data_i on each trnfer_cmplte_i. Address 4 read returns that register. Reset value 0x00.
- Undefined: address 4 read returns spi_read_data_i directly, combinational.

## Test plan
- Reset: assert rst -> all outputs 0 except spi_cs_reg_o = 0xFF; data_o = 0x00 at addresses 0, 1, 2, 6, 7.
- Divisor and mode: write 0x34 to addr 0, 0x12 to addr 1, 0x9C to addr 2 -> divisor_o = 0x1234; spe/cpol/cpha/spc0 = 1; lsbfe = 0; readback matches.
- Command with SPE=0: write 0x90 to addr 3 -> start_o, write_o stay 0; tip_o = 0.
- Transfer: SPE=1; write 0x90 to addr 3 -> start_o = write_o = 1, tip_o = 1; pulse trnfer_cmplte_i -> next edge all command bits 0, tip_o = 0, STATUS bit 0 = 1.
- Interrupt: IEN=1; pulse irq_read_i -> intr_o = 1 one cycle after IF; IACK in the same cycle as a new trnfer_cmplte_i -> IF stays 1; a later IACK alone -> intr_o = 0.
- RX path: drive spi_read_data_i = 0xA5 and pulse trnfer_cmplte_i, then change the input to 0x00 -> addr 4 reads 0xA5 with the macro defined, 0x00 without it.

Source files
------------

// File: rtl/spi_master_regs.sv
// Control/status register file for the SPI master: divisor, mode, chip-select,
// bit-count, TX data, command bits, TIP and interrupt. Option: SPIREGS_RX_CAPTURE_EN.
module spi_master_regs (
  input  logic       wb_clk,
  input  logic       rst,
  input  logic       rst_sync_i,
  input  logic [2:0] ad_i,
  input  logic       wr_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic [15:0] divisor_o,
  output logic       spe_o,
  output logic       bidiroen_o,
  output logic       spc0_o,
  output logic       cpol_o,
  output logic       cpha_o,
  output logic       lsbfe_o,
  output logic       ext_spi_clk_en_o,
  output logic [2:0] ext_spi_clk_cnt_o,
  output logic [2:0] spi_bit_ctrl_o,
  output logic       start_o,
  output logic       stop_o,
  output logic       read_o,
  output logic       write_o,
  input  logic       trnfer_cmplte_i,
  output logic [7:0] spi_write_data_o,
  input  logic [7:0] spi_read_data_i,
  output logic [7:0] spi_cs_reg_o,
  input  logic       irq_read_i,
  input  logic       irq_write_i,
  output logic       intr_o,
  output logic       tip_o
);

  logic [15:0] r_div;
  logic [7:0]  r_ctrl;
  logic [3:0]  r_cmd;
  logic        r_if;
  logic        r_intr;
  logic [7:0]  r_tx;
  logic [7:0]  r_cs;
  logic [2:0]  r_bit_ctrl;
  logic [2:0]  r_ext_cnt;
  logic [7:0]  w_rx;
  logic        w_cmd_wr;
  logic        w_irq_set;

  assign w_cmd_wr  = wr_i && (ad_i == 3'd3);
  assign w_irq_set = trnfer_cmplte_i | irq_read_i | irq_write_i;

  always_ff @(posedge wb_clk or posedge rst) begin
    if (rst) begin
      r_div      <= 16'h0000;
      r_ctrl     <= 8'h00;
      r_cmd      <= 4'h0;
      r_if       <= 1'b0;
      r_intr     <= 1'b0;
      r_tx       <= 8'h00;
      r_cs       <= 8'hFF;
      r_bit_ctrl <= 3'd0;
      r_ext_cnt  <= 3'd0;
    end else if (rst_sync_i) begin
      r_div      <= 16'h0000;
      r_ctrl     <= 8'h00;
      r_cmd      <= 4'h0;
      r_if       <= 1'b0;
      r_intr     <= 1'b0;
      r_tx       <= 8'h00;
      r_cs       <= 8'hFF;
      r_bit_ctrl <= 3'd0;
      r_ext_cnt  <= 3'd0;
    end else begin
      if (wr_i) begin
        case (ad_i)
          3'd0: r_div[7:0]  <= data_i;
          3'd1: r_div[15:8] <= data_i;
          3'd2: r_ctrl      <= data_i;
          3'd4: r_tx        <= data_i;
          3'd5: r_cs        <= data_i;
          3'd6: begin
            r_bit_ctrl <= data_i[2:0];
            r_ext_cnt  <= data_i[6:4];
          end
          default: ;
        endcase
      end
      // A new command written while enabled takes priority over completion.
      if (w_cmd_wr && r_ctrl[7])
        r_cmd <= data_i[7:4];
      else if (trnfer_cmplte_i)
        r_cmd <= 4'h0;
      if (w_irq_set)
        r_if <= 1'b1;
      else if (w_cmd_wr && data_i[0])
        r_if <= 1'b0;
      r_intr <= r_if & r_ctrl[6];
    end
  end

`ifdef SPIREGS_RX_CAPTURE_EN
  logic [7:0] r_rx;
  always_ff @(posedge wb_clk or posedge rst) begin
    if (rst)
      r_rx <= 8'h00;
    else if (rst_sync_i)
      r_rx <= 8'h00;
    else if (trnfer_cmplte_i)
      r_rx <= spi_read_data_i;
  end
  assign w_rx = r_rx;
`else
  assign w_rx = spi_read_data_i;
`endif

  always_comb begin
    data_o = 8'h00;
    case (ad_i)
      3'd0: data_o = r_div[7:0];
      3'd1: data_o = r_div[15:8];
      3'd2: data_o = r_ctrl;
      3'd3: data_o = {tip_o, 4'b0000, irq_write_i, irq_read_i, r_if};
      3'd4: data_o = w_rx;
      3'd5: data_o = r_cs;
      3'd6: data_o = {1'b0, r_ext_cnt, 1'b0, r_bit_ctrl};
      default: data_o = 8'h00;
    endcase
  end

  assign divisor_o         = r_div;
  assign spe_o             = r_ctrl[7];
  assign bidiroen_o        = r_ctrl[5];
  assign spc0_o            = r_ctrl[4];
  assign cpol_o            = r_ctrl[3];
  assign cpha_o            = r_ctrl[2];
  assign lsbfe_o           = r_ctrl[1];
  assign ext_spi_clk_en_o  = r_ctrl[0];
  assign ext_spi_clk_cnt_o = r_ext_cnt;
  assign spi_bit_ctrl_o    = r_bit_ctrl;
  assign start_o           = r_cmd[3];
  assign stop_o            = r_cmd[2];
  assign read_o            = r_cmd[1];
  assign write_o           = r_cmd[0];
  assign tip_o             = |r_cmd;
  assign intr_o            = r_intr;
  assign spi_write_data_o  = r_tx;
  assign spi_cs_reg_o      = r_cs;

endmodule

// File: tb/tb_spi_master_regs.sv
// Bench for spi_master_regs: directed test-plan steps then random traffic,
// all checked against a register-map model held in the bench.
`timescale 1ns/1ps
module tb_spi_master_regs;

  logic       wb_clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_sync_i = 1'b0;
  logic [2:0] ad_i = 3'd0;
  logic       wr_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic [7:0] data_o;
  logic [15:0] divisor_o;
  logic spe_o, bidiroen_o, spc0_o, cpol_o, cpha_o, lsbfe_o, ext_spi_clk_en_o;
  logic [2:0] ext_spi_clk_cnt_o, spi_bit_ctrl_o;
  logic start_o, stop_o, read_o, write_o;
  logic trnfer_cmplte_i = 1'b0;
  logic [7:0] spi_write_data_o;
  logic [7:0] spi_read_data_i = 8'h00;
  logic [7:0] spi_cs_reg_o;
  logic irq_read_i = 1'b0, irq_write_i = 1'b0;
  logic intr_o, tip_o;

  int vectors = 0;
  int miscompares = 0;

  spi_master_regs dut (
    .wb_clk(wb_clk), .rst(rst), .rst_sync_i(rst_sync_i), .ad_i(ad_i), .wr_i(wr_i),
    .data_i(data_i), .data_o(data_o), .divisor_o(divisor_o), .spe_o(spe_o),
    .bidiroen_o(bidiroen_o), .spc0_o(spc0_o), .cpol_o(cpol_o), .cpha_o(cpha_o),
    .lsbfe_o(lsbfe_o), .ext_spi_clk_en_o(ext_spi_clk_en_o),
    .ext_spi_clk_cnt_o(ext_spi_clk_cnt_o), .spi_bit_ctrl_o(spi_bit_ctrl_o),
    .start_o(start_o), .stop_o(stop_o), .read_o(read_o), .write_o(write_o),
    .trnfer_cmplte_i(trnfer_cmplte_i), .spi_write_data_o(spi_write_data_o),
    .spi_read_data_i(spi_read_data_i), .spi_cs_reg_o(spi_cs_reg_o),
    .irq_read_i(irq_read_i), .irq_write_i(irq_write_i), .intr_o(intr_o), .tip_o(tip_o)
  );

  // clock / reset
  always #5 wb_clk = ~wb_clk;

  // reference model: register map contents as the bus sees them
  logic [7:0] m_regs [0:7];
  logic [3:0] m_cmd;
  logic       m_if, m_intr;
  logic [7:0] m_tx, m_rx;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_regs[5] = 8'hFF;
    m_cmd = 4'h0; m_if = 1'b0; m_intr = 1'b0; m_tx = 8'h00; m_rx = 8'h00;
  endtask

  task automatic model_step();
    logic [7:0] old_ctrl;
    logic       old_if;
    logic       is_cmd;
    old_ctrl = m_regs[2];
    old_if   = m_if;
    is_cmd   = wr_i && (ad_i == 3'd3);
    if (wr_i) begin
      if (ad_i == 3'd4) m_tx = data_i;
      else if (ad_i == 3'd6) m_regs[6] = data_i & 8'h77;
      else if (ad_i != 3'd3 && ad_i != 3'd7) m_regs[ad_i] = data_i;
    end
    if (is_cmd && old_ctrl[7]) m_cmd = data_i[7:4];
    else if (trnfer_cmplte_i) m_cmd = 4'h0;
    if (trnfer_cmplte_i || irq_read_i || irq_write_i) m_if = 1'b1;
    else if (is_cmd && data_i[0]) m_if = 1'b0;
    m_intr = old_if && old_ctrl[6];
    if (trnfer_cmplte_i) m_rx = spi_read_data_i;
  endtask

  function automatic logic [7:0] exp_read(input int a);
    case (a)
      3: exp_read = {(m_cmd != 4'h0), 4'b0000, irq_write_i, irq_read_i, m_if};
`ifdef SPIREGS_RX_CAPTURE_EN
      4: exp_read = m_rx;
`else
      4: exp_read = spi_read_data_i;
`endif
      default: exp_read = m_regs[a];
    endcase
  endfunction

  // scoreboard
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] c;
    c = m_regs[2];
    chk("divisor", divisor_o, {m_regs[1], m_regs[0]});
    chk("mode", {8'h00, spe_o, 1'b0, bidiroen_o, spc0_o, cpol_o, cpha_o, lsbfe_o, ext_spi_clk_en_o},
        {8'h00, c[7], 1'b0, c[5:0]});
    chk("ext_cnt", {13'd0, ext_spi_clk_cnt_o}, {13'd0, m_regs[6][6:4]});
    chk("bit_ctrl", {13'd0, spi_bit_ctrl_o}, {13'd0, m_regs[6][2:0]});
    chk("cmd", {12'd0, start_o, stop_o, read_o, write_o}, {12'd0, m_cmd});
    chk("tip", {15'd0, tip_o}, {15'd0, (m_cmd != 4'h0)});
    chk("intr", {15'd0, intr_o}, {15'd0, m_intr});
    chk("tx", {8'h00, spi_write_data_o}, {8'h00, m_tx});
    chk("cs", {8'h00, spi_cs_reg_o}, {8'h00, m_regs[5]});
    for (int a = 0; a < 8; a++) begin
      ad_i = a[2:0];
      #0.2;
      chk($sformatf("rd%0d", a), {8'h00, data_o}, {8'h00, exp_read(a)});
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge wb_clk);
    if (rst_sync_i) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    wr_i = 1'b1; ad_i = a; data_i = d;
    tick();
    wr_i = 1'b0;
  endtask

  task automatic pulse(input logic cmp, input logic ir, input logic iw);
    trnfer_cmplte_i = cmp; irq_read_i = ir; irq_write_i = iw;
    tick();
    trnfer_cmplte_i = 1'b0; irq_read_i = 1'b0; irq_write_i = 1'b0;
  endtask

  task automatic async_reset();
    @(negedge wb_clk);
    #1 rst = 1'b1;
    model_reset();
    #1 check_all();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #12 check_all();
    rst = 1'b0;

    wr_reg(3'd0, 8'h34);
    wr_reg(3'd1, 8'h12);
    wr_reg(3'd2, 8'h1C);
    wr_reg(3'd3, 8'h90);
    chk("cmd_spe0_tip", {15'd0, tip_o}, 16'd0);
    wr_reg(3'd2, 8'h9C);
    chk("divisor_1234", divisor_o, 16'h1234);
    wr_reg(3'd3, 8'h90);
    chk("start_write", {14'd0, start_o, write_o}, 16'd3);
    pulse(1'b1, 1'b0, 1'b0);
    chk("tip_fall", {15'd0, tip_o}, 16'd0);

    wr_reg(3'd2, 8'hDC);
    wr_reg(3'd3, 8'h01);
    pulse(1'b0, 1'b1, 1'b0);
    tick();
    chk("intr_set", {15'd0, intr_o}, 16'd1);
    trnfer_cmplte_i = 1'b1;
    wr_reg(3'd3, 8'h01);
    trnfer_cmplte_i = 1'b0;
    wr_reg(3'd3, 8'h01);
    tick();
    chk("intr_clr", {15'd0, intr_o}, 16'd0);

    wr_reg(3'd3, 8'hF0);
    spi_read_data_i = 8'hA5;
    pulse(1'b1, 1'b0, 1'b0);
    spi_read_data_i = 8'h00;
    tick();

    wr_reg(3'd3, 8'h30);
    async_reset();

    for (int n = 0; n < 500; n++) begin
      wr_i = ($urandom_range(0, 1) == 0);
      ad_i = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) ad_i = 3'd3;
      data_i = 8'($urandom);
      trnfer_cmplte_i = ($urandom_range(0, 6) == 0);
      irq_read_i = ($urandom_range(0, 9) == 0);
      irq_write_i = ($urandom_range(0, 9) == 0);
      spi_read_data_i = 8'($urandom);
      rst_sync_i = ($urandom_range(0, 49) == 0);
      tick();
      rst_sync_i = 1'b0;
      if ($urandom_range(0, 79) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
